// File: rtl/ysyx_23060136_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory read arbiter.
// Optional watchdog is enabled with YSYX_23060136_ARB_TIMEOUT_EN.
package ysyx_23060136_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060136_arb_watchdog.sv
// Transaction watchdog: cleared when a new AR phase starts, counts every busy cycle,
// and flags expiry once the counter saturates. Used only with YSYX_23060136_ARB_TIMEOUT_EN.
module ysyx_23060136_arb_watchdog #(
    parameter int TIMEOUT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic active_i,
    output logic expired_o
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;
    logic                 at_max_s;

    assign at_max_s  = (count_q == {TIMEOUT_W{1'b1}});
    assign expired_o = active_i & at_max_s & ~clear_i;

    // Next counter value: clear on a fresh grant, saturate at all-ones while busy.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (active_i && !at_max_s) begin
            count_d = count_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ysyx_23060136_mem_arbiter.sv
// Round-robin arbiter of IFU fetches and LSU loads onto one AXI-lite AR/R channel,
// one transaction in flight. Define YSYX_23060136_ARB_TIMEOUT_EN to add a watchdog.
module ysyx_23060136_mem_arbiter
    import ysyx_23060136_arb_pkg::*;
#(
    parameter int BITS_W    = 64,
    parameter int TIMEOUT_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_W-1:0] ARBITER_IFU_pc,
    input  logic              ARBITER_IFU_pc_valid,
    output logic              ARBITER_IFU_pc_ready,
    output logic [BITS_W-1:0] ARBITER_IFU_inst,
    output logic              ARBITER_IFU_inst_valid,
    input  logic              ARBITER_IFU_inst_ready,
    input  logic              ARBITER_IFU_flush,
    input  logic [BITS_W-1:0] ARBITER_LSU_addr,
    input  logic              ARBITER_LSU_addr_valid,
    output logic              ARBITER_LSU_addr_ready,
    output logic [BITS_W-1:0] ARBITER_LSU_data,
    output logic              ARBITER_LSU_data_valid,
    input  logic              ARBITER_LSU_data_ready,
    output logic [BITS_W-1:0] M_araddr,
    output logic              M_arvalid,
    input  logic              M_arready,
    input  logic [BITS_W-1:0] M_rdata,
    input  logic [1:0]        M_rresp,
    input  logic              M_rvalid,
    output logic              M_rready,
    output logic              ARBITER_error
);

    arb_state_t        state_q,      state_d;
    arb_owner_t        owner_q,      owner_d;
    arb_owner_t        last_grant_q, last_grant_d;
    logic [BITS_W-1:0] araddr_q,     araddr_d;
    logic              arvalid_q,    arvalid_d;
    logic              discard_q,    discard_d;
    logic              error_q,      error_d;

    logic grant_ifu_s;
    logic grant_lsu_s;
    logic busy_s;
    logic flush_hit_s;
    logic drop_s;
    logic rready_s;
    logic r_hs_s;
    logic wd_expired_s;

    assign busy_s = (state_q == ARB_AR) || (state_q == ARB_R);

    // IFU wins unless the LSU also asks and the IFU was served last.
    assign grant_ifu_s = (state_q == ARB_IDLE) & ARBITER_IFU_pc_valid &
                         (~ARBITER_LSU_addr_valid | (last_grant_q == OWN_LSU));
    assign grant_lsu_s = (state_q == ARB_IDLE) & ARBITER_LSU_addr_valid & ~grant_ifu_s;

    // A flush landing in the same cycle as the R beat still drops that beat.
    assign flush_hit_s = ARBITER_IFU_flush & busy_s & (owner_q == OWN_IFU);
    assign drop_s      = discard_q | flush_hit_s;

`ifdef YSYX_23060136_ARB_TIMEOUT_EN
    localparam logic IDLE_RREADY = 1'b1;
    logic wd_clear_s;
    assign wd_clear_s = grant_ifu_s | grant_lsu_s;
    ysyx_23060136_arb_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear_s),
        .active_i  (busy_s),
        .expired_o (wd_expired_s)
    );
`else
    localparam logic IDLE_RREADY = 1'b0;
    // Without the watchdog nothing can expire; the width only has to be legal.
    assign wd_expired_s = (TIMEOUT_W < 32'sd1);
`endif

    // R-channel ready: late beats are swallowed in IDLE only when the watchdog exists.
    always_comb begin
        rready_s = 1'b0;
        case (state_q)
            ARB_IDLE: rready_s = IDLE_RREADY;
            ARB_AR:   rready_s = 1'b0;
            ARB_R: begin
                if (drop_s) begin
                    rready_s = 1'b1;
                end else if (owner_q == OWN_IFU) begin
                    rready_s = ARBITER_IFU_inst_ready;
                end else begin
                    rready_s = ARBITER_LSU_data_ready;
                end
            end
            default:  rready_s = 1'b0;
        endcase
    end

    assign r_hs_s = (state_q == ARB_R) & M_rvalid & rready_s;

    // Next-state and register-input computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        discard_d    = discard_q;
        error_d      = error_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_ifu_s) begin
                    araddr_d     = ARBITER_IFU_pc;
                    arvalid_d    = 1'b1;
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    state_d      = ARB_AR;
                end else if (grant_lsu_s) begin
                    araddr_d     = ARBITER_LSU_addr;
                    arvalid_d    = 1'b1;
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    state_d      = ARB_AR;
                end else begin
                    state_d      = ARB_IDLE;
                end
            end
            ARB_AR: begin
                if (flush_hit_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (M_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ARB_R;
                end else begin
                    state_d   = ARB_AR;
                end
            end
            ARB_R: begin
                if (r_hs_s) begin
                    discard_d = 1'b0;
                    state_d   = ARB_IDLE;
                    if (resp_is_error(M_rresp)) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                end else if (flush_hit_s) begin
                    discard_d = 1'b1;
                end else begin
                    state_d   = ARB_R;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                arvalid_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
        // Watchdog expiry abandons the transaction regardless of where it stands.
        if (wd_expired_s) begin
            state_d   = ARB_IDLE;
            arvalid_d = 1'b0;
            discard_d = 1'b0;
            error_d   = 1'b1;
        end else begin
            error_d   = error_d;
        end
    end

    // FSM state and registered AR-channel / error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            discard_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            discard_q    <= discard_d;
            error_q      <= error_d;
        end
    end

    assign ARBITER_IFU_pc_ready   = grant_ifu_s;
    assign ARBITER_LSU_addr_ready = grant_lsu_s;
    assign ARBITER_IFU_inst       = M_rdata;
    assign ARBITER_LSU_data       = M_rdata;
    assign ARBITER_IFU_inst_valid = (state_q == ARB_R) & (owner_q == OWN_IFU) & M_rvalid & ~drop_s;
    assign ARBITER_LSU_data_valid = (state_q == ARB_R) & (owner_q == OWN_LSU) & M_rvalid;
    assign M_araddr               = araddr_q;
    assign M_arvalid              = arvalid_q;
    assign M_rready               = rready_s;
    assign ARBITER_error          = error_q;

endmodule

// File: tb/tb_ysyx_23060136_mem_arbiter.sv
// Directed bench for ysyx_23060136_mem_arbiter: a per-cycle vector table for grant order
// and latency, then hand-written sequences for stalls, flushes, errors and reset.
module tb_ysyx_23060136_mem_arbiter;

    localparam int BW = 64;
    localparam int TW = 10;
`ifdef YSYX_23060136_ARB_TIMEOUT_EN
    localparam logic IDLE_RR = 1'b1;
`else
    localparam logic IDLE_RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] ifu_pc, lsu_addr, m_araddr, m_rdata, ifu_inst, lsu_data;
    logic          ifu_pc_valid, ifu_pc_ready, ifu_inst_valid, ifu_inst_ready, ifu_flush;
    logic          lsu_addr_valid, lsu_addr_ready, lsu_data_valid, lsu_data_ready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready, arb_error;
    logic [1:0]    m_rresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060136_mem_arbiter #(.BITS_W(BW), .TIMEOUT_W(TW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ARBITER_IFU_pc         (ifu_pc),
        .ARBITER_IFU_pc_valid   (ifu_pc_valid),
        .ARBITER_IFU_pc_ready   (ifu_pc_ready),
        .ARBITER_IFU_inst       (ifu_inst),
        .ARBITER_IFU_inst_valid (ifu_inst_valid),
        .ARBITER_IFU_inst_ready (ifu_inst_ready),
        .ARBITER_IFU_flush      (ifu_flush),
        .ARBITER_LSU_addr       (lsu_addr),
        .ARBITER_LSU_addr_valid (lsu_addr_valid),
        .ARBITER_LSU_addr_ready (lsu_addr_ready),
        .ARBITER_LSU_data       (lsu_data),
        .ARBITER_LSU_data_valid (lsu_data_valid),
        .ARBITER_LSU_data_ready (lsu_data_ready),
        .M_araddr               (m_araddr),
        .M_arvalid              (m_arvalid),
        .M_arready              (m_arready),
        .M_rdata                (m_rdata),
        .M_rresp                (m_rresp),
        .M_rvalid               (m_rvalid),
        .M_rready               (m_rready),
        .ARBITER_error          (arb_error)
    );

    typedef struct {
        string         name;
        logic          iv;
        logic [BW-1:0] pc;
        logic          lv;
        logic [BW-1:0] la;
        logic          arr;
        logic          rv;
        logic [BW-1:0] rd;
        logic          irdy;
        logic          e_iar;
        logic          e_lar;
        logic          e_arv;
        logic [BW-1:0] e_ara;
        logic          e_iv;
        logic          e_lv;
        logic          e_rr;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input string nm, input logic iv, input logic [BW-1:0] pc,
                                input logic lv, input logic [BW-1:0] la, input logic arr,
                                input logic rv, input logic [BW-1:0] rd, input logic irdy,
                                input logic e_iar, input logic e_lar, input logic e_arv,
                                input logic [BW-1:0] e_ara, input logic e_iv, input logic e_lv,
                                input logic e_rr);
        vec_t v;
        v.name = nm; v.iv = iv; v.pc = pc; v.lv = lv; v.la = la; v.arr = arr; v.rv = rv;
        v.rd = rd; v.irdy = irdy; v.e_iar = e_iar; v.e_lar = e_lar; v.e_arv = e_arv;
        v.e_ara = e_ara; v.e_iv = e_iv; v.e_lv = e_lv; v.e_rr = e_rr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifu_pc = '0; ifu_pc_valid = 1'b0; ifu_inst_ready = 1'b1; ifu_flush = 1'b0;
        lsu_addr = '0; lsu_addr_valid = 1'b0; lsu_data_ready = 1'b1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
        chk("rst_araddr", m_araddr, 64'd0);
        chk("rst_error", {63'd0, arb_error}, 64'd0);
        @(negedge clk);

        // name, iv, pc, lv, la, arr, rv, rd, irdy, e_iar, e_lar, e_arv, e_ara, e_iv, e_lv, e_rr
        tbl[0]  = mk("idle0",    1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, IDLE_RR);
        tbl[1]  = mk("both_ifu", 1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 64'd0, 1'b1,
                     1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, IDLE_RR);
        tbl[2]  = mk("ar_ifu",   1'b0, 64'd0, 1'b1, 64'h8000_1000, 1'b1, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b0, 1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk("r_ifu",    1'b0, 64'd0, 1'b1, 64'h8000_1000, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1,
                     1'b0, 1'b0, 1'b0, 64'h8000_0004, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk("both_lsu", 1'b1, 64'h8000_0008, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b1, 1'b0, 64'h8000_0004, 1'b0, 1'b0, IDLE_RR);
        tbl[5]  = mk("ar_lsu",   1'b1, 64'h8000_0008, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b0, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk("r_lsu",    1'b1, 64'h8000_0008, 1'b0, 64'd0, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1,
                     1'b0, 1'b0, 1'b0, 64'h8000_1000, 1'b0, 1'b1, 1'b1);
        tbl[7]  = mk("both_ifu2",1'b1, 64'h8000_0008, 1'b1, 64'h8000_1008, 1'b0, 1'b0, 64'd0, 1'b1,
                     1'b1, 1'b0, 1'b0, 64'h8000_1000, 1'b0, 1'b0, IDLE_RR);
        tbl[8]  = mk("ar_ifu2",  1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk("r_stall",  1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b0,
                     1'b0, 1'b0, 1'b0, 64'h8000_0008, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk("r_accept", 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b1,
                     1'b0, 1'b0, 1'b0, 64'h8000_0008, 1'b1, 1'b0, 1'b1);
        tbl[11] = mk("idle1",    1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1,
                     1'b0, 1'b0, 1'b0, 64'h8000_0008, 1'b0, 1'b0, IDLE_RR);

        for (int i = 0; i < 12; i++) begin
            ifu_pc_valid = tbl[i].iv; ifu_pc = tbl[i].pc;
            lsu_addr_valid = tbl[i].lv; lsu_addr = tbl[i].la;
            m_arready = tbl[i].arr; m_rvalid = tbl[i].rv; m_rdata = tbl[i].rd;
            ifu_inst_ready = tbl[i].irdy;
            #1;
            chk({tbl[i].name, ".ifu_ready"}, {63'd0, ifu_pc_ready}, {63'd0, tbl[i].e_iar});
            chk({tbl[i].name, ".lsu_ready"}, {63'd0, lsu_addr_ready}, {63'd0, tbl[i].e_lar});
            chk({tbl[i].name, ".arvalid"}, {63'd0, m_arvalid}, {63'd0, tbl[i].e_arv});
            chk({tbl[i].name, ".araddr"}, m_araddr, tbl[i].e_ara);
            chk({tbl[i].name, ".inst_valid"}, {63'd0, ifu_inst_valid}, {63'd0, tbl[i].e_iv});
            chk({tbl[i].name, ".lsu_valid"}, {63'd0, lsu_data_valid}, {63'd0, tbl[i].e_lv});
            chk({tbl[i].name, ".rready"}, {63'd0, m_rready}, {63'd0, tbl[i].e_rr});
            if (tbl[i].e_iv) chk({tbl[i].name, ".inst"}, ifu_inst, tbl[i].rd);
            if (tbl[i].e_lv) chk({tbl[i].name, ".lsu_data"}, lsu_data, tbl[i].rd);
            @(negedge clk);
        end
        clear_inputs();

        // Slow slave: AR held five cycles, nobody else accepted meanwhile.
        lsu_addr_valid = 1'b1; lsu_addr = 64'h8000_2000;
        #1 chk("s3_lsu_grant", {63'd0, lsu_addr_ready}, 64'd1);
        @(negedge clk);
        lsu_addr_valid = 1'b0; ifu_pc_valid = 1'b1; ifu_pc = 64'h8000_000C;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("s3_arvalid_hold", {63'd0, m_arvalid}, 64'd1);
            chk("s3_araddr_hold", m_araddr, 64'h8000_2000);
            chk("s3_no_ifu_ready_ar", {63'd0, ifu_pc_ready}, 64'd0);
            @(negedge clk);
        end
        m_arready = 1'b1;
        #1 chk("s3_arvalid_last", {63'd0, m_arvalid}, 64'd1);
        @(negedge clk);
        m_arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("s3_no_ifu_ready_r", {63'd0, ifu_pc_ready}, 64'd0);
            chk("s3_lsu_wait", {63'd0, lsu_data_valid}, 64'd0);
            @(negedge clk);
        end
        m_rvalid = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("s3_lsu_valid", {63'd0, lsu_data_valid}, 64'd1);
        chk("s3_lsu_data", lsu_data, 64'h0123_4567_89AB_CDEF);
        chk("s3_ifu_ready_r2i", {63'd0, ifu_pc_ready}, 64'd0);
        @(negedge clk);

        // Flush while waiting for the beat; the late beat is drained and dropped.
        m_rvalid = 1'b0; lsu_addr_valid = 1'b1; lsu_addr = 64'h8000_3000;
        #1;
        chk("s4_ifu_grant", {63'd0, ifu_pc_ready}, 64'd1);
        chk("s4_lsu_wait", {63'd0, lsu_addr_ready}, 64'd0);
        @(negedge clk);
        m_arready = 1'b1; ifu_pc_valid = 1'b0;
        #1 chk("s4_araddr", m_araddr, 64'h8000_000C);
        @(negedge clk);
        m_arready = 1'b0; ifu_inst_ready = 1'b0; ifu_flush = 1'b1;
        #1 chk("s4_flush_rready", {63'd0, m_rready}, 64'd1);
        @(negedge clk);
        ifu_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("s4_discard_rready", {63'd0, m_rready}, 64'd1);
            chk("s4_no_lsu_ready", {63'd0, lsu_addr_ready}, 64'd0);
            @(negedge clk);
        end
        m_rvalid = 1'b1; m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("s4_drop_inst_valid", {63'd0, ifu_inst_valid}, 64'd0);
        chk("s4_drop_rready", {63'd0, m_rready}, 64'd1);
        @(negedge clk);
        m_rvalid = 1'b0; ifu_inst_ready = 1'b1;
        #1 chk("s4_lsu_next", {63'd0, lsu_addr_ready}, 64'd1);
        @(negedge clk);

        // LSU gets an error response; flush does not touch an LSU transaction.
        lsu_addr_valid = 1'b0; m_arready = 1'b1; ifu_flush = 1'b1;
        #1 chk("s5_araddr", m_araddr, 64'h8000_3000);
        @(negedge clk);
        m_arready = 1'b0; m_rvalid = 1'b1; m_rresp = 2'b10; m_rdata = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("s5_lsu_valid", {63'd0, lsu_data_valid}, 64'd1);
        chk("s5_lsu_data", lsu_data, 64'hCAFE_F00D_1234_5678);
        chk("s5_err_before", {63'd0, arb_error}, 64'd0);
        @(negedge clk);
        m_rvalid = 1'b0; m_rresp = 2'b00; ifu_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 chk("s5_err_sticky", {63'd0, arb_error}, 64'd1);
            @(negedge clk);
        end

        // Flush coinciding with the R handshake: beat dropped, FSM back in IDLE.
        ifu_pc_valid = 1'b1; ifu_pc = 64'h8000_0010;
        #1 chk("s7_ifu_grant", {63'd0, ifu_pc_ready}, 64'd1);
        @(negedge clk);
        ifu_pc_valid = 1'b0; m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0; m_rvalid = 1'b1; ifu_flush = 1'b1; ifu_inst_ready = 1'b0;
        #1;
        chk("s7_inst_valid", {63'd0, ifu_inst_valid}, 64'd0);
        chk("s7_rready", {63'd0, m_rready}, 64'd1);
        @(negedge clk);
        m_rvalid = 1'b0; ifu_flush = 1'b0; ifu_inst_ready = 1'b1; lsu_addr_valid = 1'b1;
        lsu_addr = 64'h8000_4000;
        #1;
        chk("s7_idle_grant", {63'd0, lsu_addr_ready}, 64'd1);
        chk("s7_err_sticky", {63'd0, arb_error}, 64'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of AR.
        lsu_addr_valid = 1'b0;
        #1 chk("s5_mid_ar", {63'd0, m_arvalid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_arvalid", {63'd0, m_arvalid}, 64'd0);
        chk("s5_rst_araddr", m_araddr, 64'd0);
        chk("s5_rst_error", {63'd0, arb_error}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ifu_pc_valid = 1'b1; lsu_addr_valid = 1'b1;
        #1 chk("s5_post_rst_ifu_first", {63'd0, ifu_pc_ready}, 64'd1);
        @(negedge clk);
        clear_inputs();

`ifdef YSYX_23060136_ARB_TIMEOUT_EN
        begin
            int n;
            do_reset();
            ifu_pc_valid = 1'b1; ifu_pc = 64'h8000_0040;
            #1 chk("s6_grant", {63'd0, ifu_pc_ready}, 64'd1);
            @(negedge clk);
            ifu_pc_valid = 1'b0;
            n = 0;
            while (!arb_error && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("s6_timeout_cycles", 64'(n), 64'(2 ** TW));
            #1 chk("s6_arvalid_off", {63'd0, m_arvalid}, 64'd0);
            m_rvalid = 1'b1;
            #1 chk("s6_stray_rready", {63'd0, m_rready}, 64'd1);
            @(negedge clk);
            m_rvalid = 1'b0; ifu_pc_valid = 1'b1; ifu_pc = 64'h8000_0044;
            #1 chk("s6_regrant", {63'd0, ifu_pc_ready}, 64'd1);
            @(negedge clk);
            ifu_pc_valid = 1'b0; m_arready = 1'b1;
            @(negedge clk);
            m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h7777_0000_7777_0000;
            #1 chk("s6_serviced", {63'd0, ifu_inst_valid}, 64'd1);
            @(negedge clk);
            clear_inputs();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
